// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between fetch and memory stages; 3+ cycles per transaction, bus fields latched at grant.
// Requesters stall until their one-cycle ready pulse; bus_req is held until bus_ack or the TIMEOUT abort.
module mem_port_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_ready,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ready,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        if_stall,
    output logic        mem_stall,
    output logic        bus_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INST = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic [7:0] cnt;
    logic       last_data;
    logic       gnt_data;

    // Data wins a tie unless it was the previous grant.
    logic pick_data;
    assign pick_data = data_req & (~inst_req | ~last_data);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            last_data  <= 1'b0;
            gnt_data   <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_be     <= 4'h0;
            bus_addr   <= 32'h0;
            bus_wdata  <= 32'h0;
            inst_rdata <= 32'h0;
            data_rdata <= 32'h0;
            inst_ready <= 1'b0;
            data_ready <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            inst_ready <= 1'b0;
            data_ready <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_data) begin
                        state     <= S_DATA;
                        gnt_data  <= 1'b1;
                        bus_req   <= 1'b1;
                        bus_we    <= data_we;
                        bus_be    <= data_we ? data_be : 4'hF;
                        bus_addr  <= data_addr;
                        bus_wdata <= data_wdata;
                        cnt       <= 8'd0;
                    end else if (inst_req) begin
                        state     <= S_INST;
                        gnt_data  <= 1'b0;
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_be    <= 4'hF;
                        bus_addr  <= inst_addr;
                        bus_wdata <= 32'h0;
                        cnt       <= 8'd0;
                    end
                end
                S_INST, S_DATA: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        state   <= S_RESP;
                        if (gnt_data) begin
                            data_ready <= 1'b1;
                            if (!bus_we) data_rdata <= bus_rdata;
                        end else begin
                            inst_ready <= 1'b1;
                            inst_rdata <= bus_rdata;
                        end
                    end else if (cnt == CNT_LAST) begin
                        // Abort: complete with zero data and flag the error alongside ready.
                        bus_req <= 1'b0;
                        state   <= S_RESP;
                        bus_err <= 1'b1;
                        if (gnt_data) begin
                            data_ready <= 1'b1;
                            data_rdata <= 32'h0;
                        end else begin
                            inst_ready <= 1'b1;
                            inst_rdata <= 32'h0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    last_data <= gnt_data;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign if_stall  = inst_req & ~inst_ready;
    assign mem_stall = data_req & ~data_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: per-cycle vector table plus a hand-written async-reset sequence.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ready;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ready;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        if_stall;
    logic        mem_stall;
    logic        bus_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .inst_ready (inst_ready),
        .data_req   (data_req),
        .data_we    (data_we),
        .data_be    (data_be),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .data_ready (data_ready),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_be     (bus_be),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack),
        .if_stall   (if_stall),
        .mem_stall  (mem_stall),
        .bus_err    (bus_err)
    );

    typedef struct packed {
        logic        rstn;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [31:0] rdata;
        logic        ack;
        logic        breq;
        logic        bwe;
        logic [3:0]  bbe;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic        irdy;
        logic [31:0] irdata;
        logic        drdy;
        logic [31:0] drdata;
        logic        berr;
        logic        istall;
        logic        mstall;
    } vec_t;

    vec_t tbl[$];
    vec_t cur;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic check_row(input int i, input vec_t v);
        chk($sformatf("r%0d bus_req", i),    32'(bus_req),    32'(v.breq));
        chk($sformatf("r%0d bus_we", i),     32'(bus_we),     32'(v.bwe));
        chk($sformatf("r%0d bus_be", i),     32'(bus_be),     32'(v.bbe));
        chk($sformatf("r%0d bus_addr", i),   bus_addr,        v.baddr);
        chk($sformatf("r%0d bus_wdata", i),  bus_wdata,       v.bwdata);
        chk($sformatf("r%0d inst_ready", i), 32'(inst_ready), 32'(v.irdy));
        chk($sformatf("r%0d inst_rdata", i), inst_rdata,      v.irdata);
        chk($sformatf("r%0d data_ready", i), 32'(data_ready), 32'(v.drdy));
        chk($sformatf("r%0d data_rdata", i), data_rdata,      v.drdata);
        chk($sformatf("r%0d bus_err", i),    32'(bus_err),    32'(v.berr));
        chk($sformatf("r%0d if_stall", i),   32'(if_stall),   32'(v.istall));
        chk($sformatf("r%0d mem_stall", i),  32'(mem_stall),  32'(v.mstall));
    endtask

    initial begin
        // Inputs of each row are applied just after an edge; expectations describe the cycle after the next edge.
        cur = '0;
        // Contention from reset: data, inst, data, inst.
        cur.ireq = 1; cur.dreq = 1; cur.iaddr = 32'h10; cur.daddr = 32'h200; cur.dbe = 4'h5;
        cur.istall = 1; cur.mstall = 1;                                        tbl.push_back(cur);
        cur.rstn = 1; cur.breq = 1; cur.bbe = 4'hF; cur.baddr = 32'h200;       tbl.push_back(cur);
        cur.ack = 1; cur.rdata = 32'hA1; cur.breq = 0; cur.drdy = 1;
        cur.drdata = 32'hA1; cur.mstall = 0;                                   tbl.push_back(cur);
        cur.ack = 0; cur.drdy = 0; cur.mstall = 1;                             tbl.push_back(cur);
        cur.breq = 1; cur.baddr = 32'h10;                                      tbl.push_back(cur);
        cur.ack = 1; cur.rdata = 32'hB2; cur.breq = 0; cur.irdy = 1;
        cur.irdata = 32'hB2; cur.istall = 0;                                   tbl.push_back(cur);
        cur.ack = 0; cur.irdy = 0; cur.istall = 1;                             tbl.push_back(cur);
        cur.breq = 1; cur.baddr = 32'h200;                                     tbl.push_back(cur);
        cur.ack = 1; cur.rdata = 32'hC3; cur.breq = 0; cur.drdy = 1;
        cur.drdata = 32'hC3; cur.mstall = 0;                                   tbl.push_back(cur);
        cur.ack = 0; cur.drdy = 0; cur.mstall = 1;                             tbl.push_back(cur);
        cur.breq = 1; cur.baddr = 32'h10;                                      tbl.push_back(cur);
        cur.ack = 1; cur.rdata = 32'hD4; cur.breq = 0; cur.irdy = 1;
        cur.irdata = 32'hD4; cur.istall = 0;                                   tbl.push_back(cur);
        cur.ack = 0; cur.ireq = 0; cur.dreq = 0; cur.iaddr = 0; cur.daddr = 0; cur.dbe = 0;
        cur.irdy = 0; cur.mstall = 0;                                          tbl.push_back(cur);
        // Single fetch, address changed after grant.
        cur.ireq = 1; cur.iaddr = 32'h40; cur.breq = 1; cur.baddr = 32'h40; cur.istall = 1; tbl.push_back(cur);
        cur.iaddr = 32'h80;                                                    tbl.push_back(cur);
        cur.ack = 1; cur.rdata = 32'h2408_0005; cur.breq = 0; cur.irdy = 1;
        cur.irdata = 32'h2408_0005; cur.istall = 0;                            tbl.push_back(cur);
        cur.ack = 0; cur.ireq = 0; cur.iaddr = 0; cur.irdy = 0;                tbl.push_back(cur);
        // Store, ack after 3 wait cycles (same cycle as the timeout compare).
        cur.dreq = 1; cur.dwe = 1; cur.dbe = 4'h3; cur.daddr = 32'h100; cur.dwdata = 32'hDEAD_BEEF;
        cur.breq = 1; cur.bwe = 1; cur.bbe = 4'h3; cur.baddr = 32'h100;
        cur.bwdata = 32'hDEAD_BEEF; cur.mstall = 1;                            tbl.push_back(cur);
        for (int k = 0; k < 3; k++)                                            tbl.push_back(cur);
        cur.ack = 1; cur.rdata = 32'h1234_5678; cur.breq = 0; cur.drdy = 1; cur.mstall = 0; tbl.push_back(cur);
        cur.ack = 0; cur.dreq = 0; cur.dwe = 0; cur.dbe = 0; cur.daddr = 0; cur.dwdata = 0;
        cur.drdy = 0;                                                          tbl.push_back(cur);
        // Load that times out.
        cur.dreq = 1; cur.daddr = 32'h300; cur.breq = 1; cur.bwe = 0; cur.bbe = 4'hF;
        cur.baddr = 32'h300; cur.bwdata = 0; cur.mstall = 1;                   tbl.push_back(cur);
        for (int k = 0; k < 3; k++)                                            tbl.push_back(cur);
        cur.breq = 0; cur.drdy = 1; cur.berr = 1; cur.drdata = 0; cur.mstall = 0; tbl.push_back(cur);
        cur.dreq = 0; cur.daddr = 0; cur.drdy = 0; cur.berr = 0;              tbl.push_back(cur);
        // Stray ack in IDLE.
        cur.ack = 1; cur.rdata = 32'hFFFF_FFFF;                                tbl.push_back(cur);
        cur.ack = 0;                                                           tbl.push_back(cur);

        foreach (tbl[i]) begin
            rstn       = tbl[i].rstn;
            inst_req   = tbl[i].ireq;
            inst_addr  = tbl[i].iaddr;
            data_req   = tbl[i].dreq;
            data_we    = tbl[i].dwe;
            data_be    = tbl[i].dbe;
            data_addr  = tbl[i].daddr;
            data_wdata = tbl[i].dwdata;
            bus_rdata  = tbl[i].rdata;
            bus_ack    = tbl[i].ack;
            @(posedge clk); #1;
            check_row(i, tbl[i]);
        end

        // Reset in the middle of a load, then a late ack after release.
        data_req = 1; data_addr = 32'h400;
        @(posedge clk); #1;
        chk("mid bus_req", 32'(bus_req), 32'd1);
        chk("mid bus_addr", bus_addr, 32'h400);
        @(posedge clk); #3;
        rstn = 0;
        #1;
        chk("rst bus_req", 32'(bus_req), 32'd0);
        chk("rst bus_addr", bus_addr, 32'h0);
        chk("rst bus_be", 32'(bus_be), 32'h0);
        chk("rst inst_rdata", inst_rdata, 32'h0);
        chk("rst mem_stall", 32'(mem_stall), 32'd1);
        data_req = 0; data_addr = 0;
        @(posedge clk); #1;
        rstn = 1;
        bus_ack = 1; bus_rdata = 32'h55;
        @(posedge clk); #1;
        bus_ack = 0;
        chk("late data_ready", 32'(data_ready), 32'd0);
        chk("late bus_req", 32'(bus_req), 32'd0);
        chk("late data_rdata", data_rdata, 32'h0);
        @(posedge clk); #1;
        chk("late data_ready2", 32'(data_ready), 32'd0);
        chk("late inst_ready2", 32'(inst_ready), 32'd0);
        chk("late bus_err2", 32'(bus_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
